// File: rtl/io_timer_pkg.sv
// Shared definitions for the io_timer bus peripheral: register map, CTRL bits
// and the byte-lane write merge helper.
package io_timer_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PRESC_W = 16;

    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_LOAD   = 32'h04;
    localparam logic [31:0] OFF_COUNT  = 32'h08;
    localparam logic [31:0] OFF_STATUS = 32'h0C;
    localparam logic [31:0] OFF_PRESC  = 32'h10;

    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_RELOAD    = 1;
    localparam int unsigned CTRL_IE        = 2;
    localparam int unsigned STATUS_PENDING = 0;

    // Replace each byte of old whose enable is set; wbe[3] owns bits [31:24].
    function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [3:0]        wbe);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = wbe[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/io_timer_tick_gen.sv
// Prescaler: emits a one-cycle tick every div+1 enabled cycles.
module tick_gen
    import io_timer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    assign tick = en & (pcnt == div);

    // Held at zero while disabled, so enabling always starts a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (!en || clr || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped interval timer with prescaler, reload/one-shot modes and a
// level interrupt held until software clears the pending flag.
module io_timer
    import io_timer_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'hFFFF_0000,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wbe,
    input  logic              rden,
    output logic [DATA_W-1:0] rdata,
    output logic              hit,
    output logic              intr
);

    logic               en, reload, ie, pending;
    logic [DATA_W-1:0]  load, count;
    logic [PRESC_W-1:0] presc;

    logic [31:0]       off;
    logic              we, wr_ctrl, wr_load, wr_count, wr_status, wr_presc;
    logic              tick, expire, w1c;
    logic [DATA_W-1:0] ctrl_m, load_m, count_m, stat_m, presc_m;
    logic              unused_bits;

    // Address decode; the low two address bits never select a register.
    assign hit = (addr[31:ADDR_W] == BASE[31:ADDR_W]);
    assign off = 32'(addr[ADDR_W-1:0]) & 32'hFFFF_FFFC;
    assign we  = hit & (|wbe);

    assign wr_ctrl   = we & (off == OFF_CTRL);
    assign wr_load   = we & (off == OFF_LOAD);
    assign wr_count  = we & (off == OFF_COUNT);
    assign wr_status = we & (off == OFF_STATUS);
    assign wr_presc  = we & (off == OFF_PRESC);

    assign ctrl_m  = merge_be(32'({ie, reload, en}), wdata, wbe);
    assign load_m  = merge_be(load, wdata, wbe);
    assign count_m = merge_be(count, wdata, wbe);
    assign stat_m  = merge_be('0, wdata, wbe);
    assign presc_m = merge_be(32'(presc), wdata, wbe);
    assign w1c     = wr_status & stat_m[STATUS_PENDING];

    assign unused_bits = ^{ctrl_m[31:3], stat_m[31:1], presc_m[31:16]};

    tick_gen u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (wr_count),
        .div  (presc),
        .tick (tick)
    );

    assign expire = tick & (count == '0);

    // Software writes take priority over the hardware count/enable updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en      <= 1'b0;
            reload  <= 1'b0;
            ie      <= 1'b0;
            load    <= '0;
            count   <= '0;
            pending <= 1'b0;
            presc   <= '0;
            intr    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en     <= ctrl_m[CTRL_EN];
                reload <= ctrl_m[CTRL_RELOAD];
                ie     <= ctrl_m[CTRL_IE];
            end else if (expire && !reload) begin
                en <= 1'b0;
            end

            if (wr_count) begin
                count <= count_m;
            end else if (tick) begin
                if (count != '0) begin
                    count <= count - DATA_W'(1);
                end else if (reload) begin
                    count <= load;
                end
            end

            if (wr_load) begin
                load <= load_m;
            end
            if (wr_presc) begin
                presc <= presc_m[PRESC_W-1:0];
            end

            // An expiry in the same cycle as a clear keeps the flag set.
            pending <= (pending & ~w1c) | expire;
            intr    <= pending & ie;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit && rden) begin
            case (off)
                OFF_CTRL:   rdata = 32'({ie, reload, en});
                OFF_LOAD:   rdata = load;
                OFF_COUNT:  rdata = count;
                OFF_STATUS: rdata = 32'(pending);
                OFF_PRESC:  rdata = 32'(presc);
                default:    rdata = '0;
            endcase
        end
    end

endmodule
